// File: rtl/pb_port_decoder_if.sv
// PicoBlaze port bus between the CPU (master) and a port decoder (slave).
// Latency: none, plain wires; the decoder registers in_port.
// Backpressure: none, the CPU strobes are single-cycle and always accepted.
interface pb_port_decoder_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       read_strobe;

    modport master (
        output port_id,
        output out_port,
        output write_strobe,
        output read_strobe,
        input  in_port
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  write_strobe,
        input  read_strobe,
        output in_port
    );
endinterface

// File: rtl/pb_port_decoder.sv
// PicoBlaze output-port decoder: mode/button/control/flag registers, timed button pulses, read-back.
// Latency: registers and in_port update on the strobe edge (1 cycle); bot_out is combinational from registers.
// Backpressure: none, every write/read strobe is consumed on its edge.
module pb_port_decoder #(
    parameter int         N_MODOS    = 3,
    parameter int         N_BOT      = 4,
    parameter int         HOLD_CYC   = 4,
    parameter logic [7:0] ADDR_MODO  = 8'h01,
    parameter logic [7:0] ADDR_BOT   = 8'h22,
    parameter logic [7:0] ADDR_CTRL  = 8'h10,
    parameter logic [7:0] ADDR_FLAGS = 8'h20
) (
    input  logic                     reloj,
    input  logic                     resetM,
    pb_port_decoder_if.slave         pb,
    output logic [N_MODOS-1:0]       modo,
    output logic [N_MODOS*N_BOT-1:0] bot_out,
    output logic [1:0]               control,
    output logic [2:0]               flags,
    output logic                     bot_busy
);
    localparam int            CW      = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC);
    localparam bit            HOLD_EN = (HOLD_CYC > 0);

    logic [N_MODOS-1:0] modo_q, modo_d, mode_sel;
    logic [N_BOT-1:0]   bot_q, bot_d, bot_sel;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [2:0]         flags_q, flags_d;
    logic [7:0]         in_q, in_d;

    logic mode_wr, bot_wr, ctrl_wr, flags_wr, bot_rd, expire;

    assign mode_wr  = pb.write_strobe && (pb.port_id == ADDR_MODO);
    assign bot_wr   = pb.write_strobe && (pb.port_id == ADDR_BOT);
    assign ctrl_wr  = pb.write_strobe && (pb.port_id == ADDR_CTRL);
    assign flags_wr = pb.write_strobe && (pb.port_id == ADDR_FLAGS);
    assign bot_rd   = pb.read_strobe  && (pb.port_id == ADDR_BOT);

    // A button or mode write on the last hold cycle replaces the pulse, so it never counts as expired.
    assign expire = busy_q && (cnt_q == CW'(1)) && !mode_wr && !bot_wr;

    // Value k selects bit N-k; out-of-range values give an all-zero selector.
    always_comb begin
        mode_sel = '0;
        for (int m = 0; m < N_MODOS; m++) begin
            mode_sel[m] = (pb.out_port == 8'(N_MODOS - m));
        end
    end

    always_comb begin
        bot_sel = '0;
        for (int b = 0; b < N_BOT; b++) begin
            bot_sel[b] = (pb.out_port == 8'(N_BOT - b));
        end
    end

    always_comb begin
        modo_d  = modo_q;
        bot_d   = bot_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ctrl_d  = ctrl_q;
        flags_d = flags_q;

        if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
        end

        if (expire) begin
            bot_d  = '0;
            busy_d = 1'b0;
            done_d = 1'b1;
        end else if (bot_rd) begin
            done_d = 1'b0;
        end

        if (mode_wr) begin
            modo_d = ((modo_q & mode_sel) != '0) ? '0 : mode_sel;
            bot_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end

        if (bot_wr) begin
            bot_d = bot_sel;
            if (HOLD_EN && (bot_sel != '0)) begin
                cnt_d  = HOLD_LD;
                busy_d = 1'b1;
            end else begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        end

        if (ctrl_wr) begin
            ctrl_d = pb.out_port[1:0];
        end
        if (flags_wr) begin
            flags_d = pb.out_port[2:0];
        end
    end

    // Read-back samples pre-edge state, so a clearing read still returns done=1.
    always_comb begin
        in_d = 8'h00;
        if (pb.port_id == ADDR_MODO) begin
            in_d = 8'(modo_q);
        end else if (pb.port_id == ADDR_BOT) begin
            in_d = {done_q, 7'(bot_q)};
        end else if (pb.port_id == ADDR_CTRL) begin
            in_d = {6'b0, ctrl_q};
        end else if (pb.port_id == ADDR_FLAGS) begin
            in_d = {5'b0, flags_q};
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            modo_q  <= '0;
            bot_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ctrl_q  <= '0;
            flags_q <= '0;
            in_q    <= '0;
        end else begin
            modo_q  <= modo_d;
            bot_q   <= bot_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ctrl_q  <= ctrl_d;
            flags_q <= flags_d;
            in_q    <= in_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_MODOS; g++) begin : g_route
            assign bot_out[g*N_BOT +: N_BOT] = modo_q[g] ? bot_q : '0;
        end
    endgenerate

    assign modo       = modo_q;
    assign control    = ctrl_q;
    assign flags      = flags_q;
    assign bot_busy   = busy_q;
    assign pb.in_port = in_q;
endmodule

// File: tb/tb_pb_port_decoder.sv
// Bench for pb_port_decoder: vector table, directed hold/done/reset sequences and random traffic vs a model.
`timescale 1ns/1ps
module tb_pb_port_decoder;
    localparam int         N_MODOS  = 3;
    localparam int         N_BOT    = 4;
    localparam int         HOLD_CYC = 4;
    localparam logic [7:0] A_MODO   = 8'h01;
    localparam logic [7:0] A_BOT    = 8'h22;
    localparam logic [7:0] A_CTRL   = 8'h10;
    localparam logic [7:0] A_FLAGS  = 8'h20;

    logic                     reloj  = 1'b0;
    logic                     resetM = 1'b0;
    logic [N_MODOS-1:0]       modo;
    logic [N_MODOS*N_BOT-1:0] bot_out;
    logic [1:0]               control;
    logic [2:0]               flags;
    logic                     bot_busy;

    pb_port_decoder_if pb();

    pb_port_decoder #(
        .N_MODOS(N_MODOS), .N_BOT(N_BOT), .HOLD_CYC(HOLD_CYC),
        .ADDR_MODO(A_MODO), .ADDR_BOT(A_BOT), .ADDR_CTRL(A_CTRL), .ADDR_FLAGS(A_FLAGS)
    ) dut (
        .reloj(reloj),
        .resetM(resetM),
        .pb(pb),
        .modo(modo),
        .bot_out(bot_out),
        .control(control),
        .flags(flags),
        .bot_busy(bot_busy)
    );

    always #5 reloj = ~reloj;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: selected mode number k (0 = none), button number v (0 = none), cycles left.
    int         m_mode = 0;
    int         m_btn  = 0;
    int         m_rem  = 0;
    bit         m_done = 1'b0;
    logic [1:0] m_ctrl = 2'b0;
    logic [2:0] m_flg  = 3'b0;
    logic [7:0] m_in   = 8'h00;

    function automatic logic [N_MODOS-1:0] exp_modo_f();
        logic [N_MODOS-1:0] r;
        r = '0;
        if (m_mode != 0) r[N_MODOS - m_mode] = 1'b1;
        return r;
    endfunction

    function automatic logic [N_BOT-1:0] exp_bot_f();
        logic [N_BOT-1:0] r;
        r = '0;
        if (m_btn != 0) r[N_BOT - m_btn] = 1'b1;
        return r;
    endfunction

    function automatic logic [N_MODOS*N_BOT-1:0] exp_bo_f();
        logic [N_MODOS*N_BOT-1:0] r;
        logic [N_MODOS-1:0]       md;
        r  = '0;
        md = exp_modo_f();
        for (int m = 0; m < N_MODOS; m++) begin
            if (md[m]) r[m*N_BOT +: N_BOT] = exp_bot_f();
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_btn = 0; m_rem = 0; m_done = 1'b0;
        m_ctrl = '0; m_flg = '0; m_in = 8'h00;
    endtask

    task automatic model_edge(input bit we, input bit re, input logic [7:0] pid, input logic [7:0] dat);
        bit bwr, mwr, expire;
        int k;
        k = int'(dat);
        if      (pid == A_MODO)  m_in = 8'(exp_modo_f());
        else if (pid == A_BOT)   m_in = {m_done, 7'(exp_bot_f())};
        else if (pid == A_CTRL)  m_in = {6'b0, m_ctrl};
        else if (pid == A_FLAGS) m_in = {5'b0, m_flg};
        else                     m_in = 8'h00;
        bwr    = we && (pid == A_BOT);
        mwr    = we && (pid == A_MODO);
        expire = (m_rem == 1) && !bwr && !mwr;
        if (m_rem > 0) m_rem--;
        if (expire) begin
            m_btn  = 0;
            m_done = 1'b1;
        end else if (re && pid == A_BOT) begin
            m_done = 1'b0;
        end
        if (mwr) begin
            if (k >= 1 && k <= N_MODOS) m_mode = (m_mode == k) ? 0 : k;
            else                        m_mode = 0;
            m_btn = 0;
            m_rem = 0;
        end
        if (bwr) begin
            if (k >= 1 && k <= N_BOT) begin
                m_btn = k;
                m_rem = HOLD_CYC;
            end else begin
                m_btn = 0;
                m_rem = 0;
            end
        end
        if (we && pid == A_CTRL)  m_ctrl = dat[1:0];
        if (we && pid == A_FLAGS) m_flg  = dat[2:0];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " modo"},     32'(modo),        32'(exp_modo_f()));
        chk({tag, " bot_out"},  32'(bot_out),     32'(exp_bo_f()));
        chk({tag, " bot_busy"}, 32'(bot_busy),    32'(m_rem > 0));
        chk({tag, " control"},  32'(control),     32'(m_ctrl));
        chk({tag, " flags"},    32'(flags),       32'(m_flg));
        chk({tag, " in_port"},  32'(pb.in_port),  32'(m_in));
    endtask

    // Drive one cycle; inputs change #1 after the edge and outputs are sampled there too.
    task automatic step(input bit we, input bit re, input logic [7:0] pid, input logic [7:0] dat);
        pb.write_strobe = we;
        pb.read_strobe  = re;
        pb.port_id      = pid;
        pb.out_port     = dat;
        @(posedge reloj);
        model_edge(we, re, pid, dat);
        #1;
        pb.write_strobe = 1'b0;
        pb.read_strobe  = 1'b0;
        check_model("model");
    endtask

    task automatic idle();
        step(1'b0, 1'b0, A_BOT, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " modo"},     32'(modo),       32'h0);
        chk({tag, " bot_out"},  32'(bot_out),    32'h0);
        chk({tag, " bot_busy"}, 32'(bot_busy),   32'h0);
        chk({tag, " control"},  32'(control),    32'h0);
        chk({tag, " flags"},    32'(flags),      32'h0);
        chk({tag, " in_port"},  32'(pb.in_port), 32'h0);
    endtask

    typedef struct {
        bit         we;
        bit         re;
        logic [7:0] pid;
        logic [7:0] dat;
        logic [2:0] e_modo;
        logic [1:0] e_ctrl;
        logic [2:0] e_flags;
        logic [7:0] e_in;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pid;
        pb.port_id = 8'h00; pb.out_port = 8'h00;
        pb.write_strobe = 1'b0; pb.read_strobe = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, A_MODO,  8'h01, 3'b100, 2'b00, 3'b000, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, A_MODO,  8'h01, 3'b000, 2'b00, 3'b000, 8'h04};
        tbl[2]  = '{1'b1, 1'b0, A_MODO,  8'h02, 3'b010, 2'b00, 3'b000, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, A_MODO,  8'h07, 3'b000, 2'b00, 3'b000, 8'h02};
        tbl[4]  = '{1'b1, 1'b0, A_CTRL,  8'hFE, 3'b000, 2'b10, 3'b000, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, A_FLAGS, 8'h05, 3'b000, 2'b10, 3'b101, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 8'h33,   8'hFF, 3'b000, 2'b10, 3'b101, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, A_CTRL,  8'h01, 3'b000, 2'b10, 3'b101, 8'h02};
        tbl[8]  = '{1'b0, 1'b1, A_FLAGS, 8'h00, 3'b000, 2'b10, 3'b101, 8'h05};
        tbl[9]  = '{1'b1, 1'b0, A_MODO,  8'h03, 3'b001, 2'b10, 3'b101, 8'h00};
        tbl[10] = '{1'b0, 1'b0, A_MODO,  8'h00, 3'b001, 2'b10, 3'b101, 8'h01};
        tbl[11] = '{1'b1, 1'b0, A_MODO,  8'h09, 3'b000, 2'b10, 3'b101, 8'h01};

        #12;
        check_all_zero("reset");
        @(posedge reloj);
        #1 resetM = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].re, tbl[i].pid, tbl[i].dat);
            chk($sformatf("vec%0d modo", i),    32'(modo),       32'(tbl[i].e_modo));
            chk($sformatf("vec%0d control", i), 32'(control),    32'(tbl[i].e_ctrl));
            chk($sformatf("vec%0d flags", i),   32'(flags),      32'(tbl[i].e_flags));
            chk($sformatf("vec%0d in_port", i), 32'(pb.in_port), 32'(tbl[i].e_in));
        end

        // Routed pulse on mode 2 lasts exactly four cycles, then done reads back once.
        step(1'b1, 1'b0, A_MODO, 8'h02);
        step(1'b1, 1'b0, A_BOT, 8'h03);
        chk("hold c0 bot_out", 32'(bot_out), 32'h020);
        chk("hold c0 busy", 32'(bot_busy), 32'h1);
        for (int c = 1; c < 4; c++) begin
            idle();
            chk($sformatf("hold c%0d bot_out", c), 32'(bot_out), 32'h020);
            chk($sformatf("hold c%0d busy", c), 32'(bot_busy), 32'h1);
        end
        idle();
        chk("hold end bot_out", 32'(bot_out), 32'h000);
        chk("hold end busy", 32'(bot_busy), 32'h0);
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("done read1", 32'(pb.in_port), 32'h80);
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("done read2", 32'(pb.in_port), 32'h00);

        // Clearing read on the expiry edge loses to expiry.
        step(1'b1, 1'b0, A_BOT, 8'h01);
        for (int c = 0; c < 3; c++) idle();
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("expiry read", 32'(pb.in_port), 32'h08);
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("expiry done kept", 32'(pb.in_port), 32'h80);
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("expiry done cleared", 32'(pb.in_port), 32'h00);

        // Restart mid-hold extends the pulse by a full hold.
        step(1'b1, 1'b0, A_BOT, 8'h01);
        idle();
        step(1'b1, 1'b0, A_BOT, 8'h04);
        chk("restart bot_out", 32'(bot_out), 32'h010);
        for (int c = 0; c < 3; c++) begin
            idle();
            chk($sformatf("restart busy%0d", c), 32'(bot_busy), 32'h1);
        end
        idle();
        chk("restart end busy", 32'(bot_busy), 32'h0);
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("restart done", 32'(pb.in_port), 32'h80);

        // Mode write aborts a hold without setting done.
        step(1'b1, 1'b0, A_BOT, 8'h02);
        idle();
        step(1'b1, 1'b0, A_MODO, 8'h02);
        chk("abort busy", 32'(bot_busy), 32'h0);
        for (int c = 0; c < 4; c++) idle();
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("abort no done", 32'(pb.in_port), 32'h00);

        // Asynchronous reset in the middle of a hold.
        step(1'b1, 1'b0, A_MODO, 8'h01);
        step(1'b1, 1'b0, A_BOT, 8'h02);
        idle();
        resetM = 1'b0;
        #1;
        check_all_zero("async reset");
        model_reset();
        @(posedge reloj);
        @(posedge reloj);
        #1 resetM = 1'b1;
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("post reset in_port", 32'(pb.in_port), 32'h00);
        for (int c = 0; c < 5; c++) idle();
        step(1'b0, 1'b1, A_BOT, 8'h00);
        chk("post reset no done", 32'(pb.in_port), 32'h00);

        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 5))
                0: pid = A_MODO;
                1: pid = A_BOT;
                2: pid = A_CTRL;
                3: pid = A_FLAGS;
                4: pid = 8'h33;
                default: pid = 8'($urandom);
            endcase
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), pid,
                 ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
